spi_master_param: RTL and testbench

Parametrised SPI master for the MicroSD path and other serial peripherals. It generalises the fixed single-device SPI block in four ways: configurable address and data widths, a programmable SCLK divider, runtime CPOL/CPHA mode, and multiple chip selects. One transaction is a single framed transfer: an R/W bit, then an address, then a data word, all MSB first, under one CS assertion. The block reports completion with a one-cycle DONE pulse.

---
 rtl/spi_master_param.sv | 182 ++++++++++++++++++
 tb/tb_spi_master_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master. One transaction is a single frame of
// 1 + ADDR_W + DATA_W bits (R/W, address, data; MSB first) under one chip select.
// Completion is signalled by a one-cycle DONE pulse.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-low reset
//   EN       start request, sampled while BUSY=0 (and in the DONE cycle)
//   RW       1=read, 0=write (latched at start)
//   mode     {CPOL,CPHA} (latched at start)
//   sel      chip-select index (latched at start)
//   addres   address (latched at start)
//   dataIN   write data (latched at start)
//   dataOUT  last word read
//   DONE     one-cycle completion pulse
//   BUSY     transfer in progress
//   SCLK     serial clock
//   MOSI     serial data out
//   MISO     serial data in (caller guarantees it is synchronous to clk)
//   CS       active-low chip selects, one-hot-low while a frame is on the bus
module spi_master_param #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned SEL_W   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  EN,
   input  logic                  RW,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [ADDR_W-1:0]     addres,
   input  logic [DATA_W-1:0]     dataIN,
   output logic [DATA_W-1:0]     dataOUT,
   output logic                  DONE,
   output logic                  BUSY,
   output logic                  SCLK,
   output logic                  MOSI,
   input  logic                  MISO,
   output logic [2**SEL_W-1:0]   CS
);

   localparam int unsigned NCs    = 2 ** SEL_W;
   localparam int unsigned FrameW = 1 + ADDR_W + DATA_W;
   localparam int unsigned HalfW  = $clog2(2 * FrameW);
   localparam int unsigned CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CntW-1:0]  CntLast  = CntW'(CLK_DIV - 1);
   localparam logic [HalfW-1:0] HalfLast = HalfW'(2 * FrameW - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StFinish} state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic [HalfW-1:0]    half_q;
   logic [FrameW-1:0]   tx_q;     // bits still to be driven, MSB next
   logic [DATA_W-1:0]   rx_q;
   logic [DATA_W-1:0]   dout_q;
   logic                rw_q;
   logic                cpol_q;
   logic                cpha_q;
   logic                sclk_q;
   logic                mosi_q;
   logic                done_q;
   logic                busy_q;
   logic [NCs-1:0]      cs_q;

   logic [FrameW-1:0]   frame_in;
   logic [FrameW-1:0]   tx_shift;
   logic [DATA_W-1:0]   rx_shift;
   logic [HalfW-1:0]    half_nxt;
   logic                sample_nxt;

   always_comb begin
      // Reads drive all-ones through the data phase.
      frame_in   = {RW, addres, RW ? {DATA_W{1'b1}} : dataIN};
      tx_shift   = FrameW'({tx_q, 1'b1});
      rx_shift   = DATA_W'({rx_q, MISO});
      half_nxt   = half_q + 1'b1;
      // Even half-periods open with a leading edge. CPHA=0 samples on leading
      // edges, CPHA=1 on trailing; the other edge type advances MOSI.
      sample_nxt = (~half_nxt[0]) ^ cpha_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         half_q  <= '0;
         tx_q    <= '1;
         rx_q    <= '0;
         dout_q  <= '0;
         rw_q    <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         cs_q    <= '1;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StFinish: begin
               if (EN) begin
                  state_q <= StSetup;
                  cnt_q   <= '0;
                  rw_q    <= RW;
                  cpol_q  <= mode[1];
                  cpha_q  <= mode[0];
                  sclk_q  <= mode[1];
                  mosi_q  <= RW;
                  tx_q    <= FrameW'({frame_in, 1'b1});
                  busy_q  <= 1'b1;
                  cs_q    <= ~(NCs'(1) << sel);
               end else begin
                  state_q <= StIdle;
               end
            end
            StSetup: begin
               if (cnt_q == CntLast) begin
                  // First leading edge; MOSI already carries bit 0.
                  state_q <= StShift;
                  cnt_q   <= '0;
                  half_q  <= '0;
                  sclk_q  <= ~cpol_q;
                  if (!cpha_q) begin
                     rx_q <= rx_shift;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StShift: begin
               if (cnt_q == CntLast) begin
                  cnt_q <= '0;
                  if (half_q == HalfLast) begin
                     // SCLK is back at CPOL after the final trailing edge.
                     state_q <= StHold;
                  end else begin
                     half_q <= half_nxt;
                     sclk_q <= ~sclk_q;
                     if (sample_nxt) begin
                        rx_q <= rx_shift;
                     end else begin
                        mosi_q <= tx_q[FrameW-1];
                        tx_q   <= tx_shift;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StHold: begin
               if (cnt_q == CntLast) begin
                  state_q <= StFinish;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  cs_q    <= '1;
                  mosi_q  <= 1'b1;
                  if (rw_q) begin
                     dout_q <= rx_q;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dataOUT = dout_q;
   assign DONE    = done_q;
   assign BUSY    = busy_q;
   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign CS      = cs_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: two instances (CLK_DIV=4 and CLK_DIV=1)
// share the request inputs; a bus-level slave model captures MOSI, drives MISO,
// and checks each frame against the expected transaction when DONE appears.
module tb_spi_master_param;

   localparam int N  = 17;
   localparam int C0 = 4;
   localparam int C1 = 1;

   typedef struct packed {
      int          inst;
      logic        rw;
      logic [1:0]  mode;
      logic        sel;
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [16:0] miso;
      int          acc;
   } txn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rw_i;
   logic [1:0]  mode_i;
   logic        sel_i;
   logic [7:0]  addr_i;
   logic [7:0]  data_i;
   logic [1:0]  rst_n, en, done, busy, sclk, mosi, miso;
   logic [7:0]  dout [2];
   logic [1:0]  cs   [2];

   spi_master_param #(.DATA_W(8), .ADDR_W(8), .CLK_DIV(C0), .SEL_W(1)) dut (
      .clk(clk), .reset(rst_n[0]), .EN(en[0]), .RW(rw_i), .mode(mode_i), .sel(sel_i),
      .addres(addr_i), .dataIN(data_i), .dataOUT(dout[0]), .DONE(done[0]),
      .BUSY(busy[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0]), .CS(cs[0])
   );

   spi_master_param #(.DATA_W(8), .ADDR_W(8), .CLK_DIV(C1), .SEL_W(1)) dut_div1 (
      .clk(clk), .reset(rst_n[1]), .EN(en[1]), .RW(rw_i), .mode(mode_i), .sel(sel_i),
      .addres(addr_i), .dataIN(data_i), .dataOUT(dout[1]), .DONE(done[1]),
      .BUSY(busy[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1]), .CS(cs[1])
   );

   int         checks = 0;
   int         errors = 0;
   txn_t       exp_q[$];
   logic [7:0] last_dout [2];

   task automatic chk(string name, int i, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s (dut%0d) cycle %0d: got 0x%0h, want 0x%0h", name, i, cyc, got, want);
      end
   endtask

   function automatic int cdiv(int i);
      return (i == 0) ? C0 : C1;
   endfunction

   // Reference model: what the wire must carry and when the frame must end.
   function automatic logic [16:0] exp_frame(txn_t t);
      return {t.rw, t.addr, t.rw ? 8'hFF : t.data};
   endfunction

   function automatic int exp_done(txn_t t);
      return t.acc + 1 + cdiv(t.inst) * (2 * N + 2);
   endfunction

   function automatic txn_t mk(int i, logic r, logic [1:0] m, logic s, logic [7:0] a,
                               logic [7:0] d, logic [16:0] mi);
      txn_t t;
      t.inst = i; t.rw = r; t.mode = m; t.sel = s; t.addr = a; t.data = d; t.miso = mi;
      t.acc = 0;
      return t;
   endfunction

   function automatic txn_t mk_rand(int i);
      return mk(i, 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                17'($urandom));
   endfunction

   task automatic drive(txn_t t);
      rw_i = t.rw; mode_i = t.mode; sel_i = t.sel; addr_i = t.addr; data_i = t.data;
   endtask

   // Called at a negedge while the target is idle or in its DONE cycle.
   task automatic issue(txn_t t);
      drive(t);
      en[t.inst] = 1'b1;
      t.acc = cyc;
      exp_q.push_back(t);
      @(negedge clk);
      en[t.inst] = 1'b0;
   endtask

   task automatic wait_done(int i);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[i] && n < 500);
      chk("done_seen", i, done[i], 1);
   endtask

   // Slave model and monitor
   logic        in_frame  [2];
   logic        prev_sclk [2];
   int          since     [2];
   int          nedges    [2];
   int          mj        [2];
   logic        hp_bad    [2];
   logic [16:0] cap       [2];
   txn_t        cur       [2];

   initial begin
      miso = '0;
      for (int i = 0; i < 2; i++) begin
         in_frame[i] = 1'b0; prev_sclk[i] = 1'b0; since[i] = 0; nedges[i] = 0;
         mj[i] = 0; hp_bad[i] = 1'b0; cap[i] = '0; cur[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            logic act, lead, samp;
            txn_t t;
            act = (cs[i] != 2'b11);
            since[i]++;
            if (done[i]) begin
               if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done (dut%0d) cycle %0d: got DONE=1, want 0", i, cyc);
               end else begin
                  t = exp_q.pop_front();
                  chk("done_cycle", i, cyc, exp_done(t));
                  chk("mosi_frame", i, 32'(cap[i]), 32'(exp_frame(t)));
                  chk("dataOUT", i, 32'(dout[i]), 32'(t.rw ? t.miso[7:0] : last_dout[i]));
                  chk("sclk_edges", i, nedges[i], 2 * N);
                  chk("half_period_bad", i, 32'(hp_bad[i]), 0);
                  chk("cs_at_done", i, 32'(cs[i]), 32'(2'b11));
                  chk("busy_at_done", i, 32'(busy[i]), 0);
                  chk("sclk_idle", i, 32'(sclk[i]), 32'(t.mode[1]));
                  chk("mosi_idle", i, 32'(mosi[i]), 1);
                  if (t.rw) last_dout[i] = t.miso[7:0];
               end
            end
            if (!act) begin
               in_frame[i] = 1'b0;
            end else if (!in_frame[i]) begin
               in_frame[i] = 1'b1; nedges[i] = 0; cap[i] = '0; mj[i] = 0;
               hp_bad[i] = 1'b0; since[i] = 0; prev_sclk[i] = sclk[i];
               if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame (dut%0d) cycle %0d: got CS=0x%0h, want idle",
                           i, cyc, cs[i]);
                  cur[i] = '0;
               end else begin
                  cur[i] = exp_q[0];
                  chk("start_cycle", i, cyc, cur[i].acc + 1);
                  chk("cs_select", i, 32'(cs[i]), 32'(cur[i].sel ? 2'b01 : 2'b10));
                  chk("busy_start", i, 32'(busy[i]), 1);
                  chk("sclk_setup", i, 32'(sclk[i]), 32'(cur[i].mode[1]));
                  chk("mosi_first", i, 32'(mosi[i]), 32'(cur[i].rw));
               end
               if (!cur[i].mode[0]) begin
                  miso[i] = cur[i].miso[N-1];
                  mj[i] = 1;
               end else begin
                  miso[i] = 1'($urandom);
               end
            end else if (sclk[i] != prev_sclk[i]) begin
               if (since[i] != cdiv(i)) hp_bad[i] = 1'b1;
               since[i] = 0;
               lead = (prev_sclk[i] == cur[i].mode[1]);
               samp = lead ^ cur[i].mode[0];
               if (samp) begin
                  cap[i] = {cap[i][15:0], mosi[i]};
               end else if (mj[i] < N) begin
                  miso[i] = cur[i].miso[N-1-mj[i]];
                  mj[i]++;
               end
               nedges[i]++;
               prev_sclk[i] = sclk[i];
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish, want finish before cycle 60000");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t, t2;
      int   tgt, seen;
      rst_n = 2'b00; en = 2'b11;
      rw_i = 1'b0; mode_i = 2'b00; sel_i = 1'b0; addr_i = '0; data_i = '0;
      last_dout[0] = '0; last_dout[1] = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_cs", i, 32'(cs[i]), 32'(2'b11));
         chk("rst_sclk", i, 32'(sclk[i]), 0);
         chk("rst_mosi", i, 32'(mosi[i]), 1);
         chk("rst_busy", i, 32'(busy[i]), 0);
         chk("rst_done", i, 32'(done[i]), 0);
         chk("rst_dout", i, 32'(dout[i]), 0);
      end
      en = 2'b00;
      rst_n = 2'b11;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) chk("idle_busy", i, 32'(busy[i]), 0);

      // Write, mode 0, sel 0
      issue(mk(0, 1'b0, 2'b00, 1'b0, 8'h55, 8'hA3, 17'($urandom)));
      wait_done(0);

      // Read, mode 3, sel 1, slave returns 0xA5
      issue(mk(0, 1'b1, 2'b11, 1'b1, 8'($urandom), 8'($urandom), {9'($urandom), 8'hA5}));
      wait_done(0);
      chk("read_word", 0, 32'(dout[0]), 32'h00A5);

      // Back-to-back: EN held high through the first DONE
      t = mk(0, 1'b0, 2'b01, 1'b0, 8'($urandom), 8'($urandom), 17'($urandom));
      drive(t);
      en[0] = 1'b1;
      t.acc = cyc;
      exp_q.push_back(t);
      @(negedge clk);
      t2 = mk(0, 1'b1, 2'b10, 1'b1, 8'($urandom), 8'($urandom), 17'($urandom));
      drive(t2);
      t2.acc = exp_done(t);
      exp_q.push_back(t2);
      wait_done(0);
      @(negedge clk);
      en[0] = 1'b0;
      chk("b2b_busy", 0, 32'(busy[0]), 1);
      wait_done(0);

      // Abort during data bit 3 of a write
      t = mk(0, 1'b0, 2'b00, 1'b1, 8'($urandom), 8'($urandom), 17'($urandom));
      tgt = cyc + 1 + C0 + 24 * C0 + 1;
      issue(t);
      while (cyc < tgt) @(negedge clk);
      rst_n[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      chk("abort_cs", 0, 32'(cs[0]), 32'(2'b11));
      chk("abort_busy", 0, 32'(busy[0]), 0);
      chk("abort_done", 0, 32'(done[0]), 0);
      chk("abort_sclk", 0, 32'(sclk[0]), 0);
      chk("abort_mosi", 0, 32'(mosi[0]), 1);
      chk("abort_dout", 0, 32'(dout[0]), 0);
      void'(exp_q.pop_back());
      last_dout[0] = '0;
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (done[0]) seen++;
      end
      chk("abort_no_done", 0, seen, 0);
      issue(mk(0, 1'b0, 2'b00, 1'b0, 8'($urandom), 8'($urandom), 17'($urandom)));
      wait_done(0);

      // EN with new inputs while busy is ignored
      t = mk(0, 1'b0, 2'b10, 1'b0, 8'($urandom), 8'($urandom), 17'($urandom));
      issue(t);
      repeat (20) @(negedge clk);
      t2 = mk(0, 1'b1, 2'b01, 1'b1, ~t.addr, ~t.data, 17'($urandom));
      drive(t2);
      en[0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("busy_hold", 0, 32'(busy[0]), 1);
      end
      en[0] = 1'b0;
      wait_done(0);

      // CLK_DIV=1, mode 1 write
      issue(mk(1, 1'b0, 2'b01, 1'b0, 8'($urandom), 8'($urandom), 17'($urandom)));
      wait_done(1);

      // Randomized traffic on both instances
      for (int k = 0; k < 12; k++) begin
         issue(mk_rand(k % 2));
         wait_done(k % 2);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", 0, exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
